// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: funct3 load/store codes,
// write-back selects, FSM states and the latched M-stage control bundle.
package mem_stage_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef struct packed {
    logic       reg_we;
    logic [2:0] op;
    logic       mem_we;
    logic [4:0] rd;
    logic [1:0] wb_ctr;
  } m_ctrl_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store replicate/byte enables, load
// shift/extend, and misalignment detection. Lane count is fixed at 4.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            i_op,
  input  logic [1:0]            i_addr_lo,
  input  logic [DATA_WIDTH-1:0] i_st_data,
  input  logic [DATA_WIDTH-1:0] i_ld_raw,
  output logic [DATA_WIDTH-1:0] o_st_wdata,
  output logic [LANES-1:0]      o_st_be,
  output logic [DATA_WIDTH-1:0] o_ld_data,
  output logic                  o_misalign
);

  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_sext;

  assign w_shift = i_ld_raw >> {i_addr_lo, 3'b000};
  assign w_sext  = ~i_op[2];

  // Store lane steering
  always_comb begin
    o_st_wdata = i_st_data;
    o_st_be    = '1;
    case (i_op[1:0])
      2'b00: begin
        o_st_wdata = DATA_WIDTH'({LANES{i_st_data[7:0]}});
        o_st_be    = 4'b0001 << i_addr_lo;
      end
      2'b01: begin
        o_st_wdata = DATA_WIDTH'({2{i_st_data[15:0]}});
        o_st_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load extraction: bit 2 of funct3 selects zero extension
  always_comb begin
    o_ld_data = i_ld_raw;
    case (i_op[1:0])
      2'b00:   o_ld_data = DATA_WIDTH'({{24{w_sext & w_shift[7]}}, w_shift[7:0]});
      2'b01:   o_ld_data = DATA_WIDTH'({{16{w_sext & w_shift[15]}}, w_shift[15:0]});
      default: ;
    endcase
  end

  always_comb begin
    o_misalign = 1'b0;
    case (i_op[1:0])
      2'b01:   o_misalign = i_addr_lo[0];
      2'b10:   o_misalign = (i_addr_lo != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: M pipeline register, data-memory req/gnt/rvalid handshake,
// load capture, and the stall raised while an access is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_wee,
  input  logic [2:0]            ope,
  input  logic                  mem_wee,
  input  logic [4:0]            rde,
  input  logic [ADDR_WIDTH-1:0] pcne,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] rd2_ture,
  input  logic [1:0]            wb_ctre,
  output logic                  reg_wem,
  output logic [4:0]            rdm,
  output logic [1:0]            wb_ctrm,
  output logic [DATA_WIDTH-1:0] alu_resultm,
  output logic [ADDR_WIDTH-1:0] pcnm,
  output logic [DATA_WIDTH-1:0] read_datam,
  output logic                  stall_m,
  output logic                  misalign_m,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [LANES-1:0]      dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  m_ctrl_t               r_ctrl;
  logic [ADDR_WIDTH-1:0] r_pcn;
  logic [DATA_WIDTH-1:0] r_alu;
  logic [DATA_WIDTH-1:0] r_rd2;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_served;
  state_t                r_state;
  state_t                w_state_nxt;

  logic                  w_load;
  logic                  w_store;
  logic                  w_mem_op;
  logic                  w_misalign_raw;
  logic                  w_misalign;
  logic                  w_pending;
  logic                  w_served_set;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] w_st_wdata;
  logic [LANES-1:0]      w_st_be;
  logic [DATA_WIDTH-1:0] w_ld_data;

  mem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .i_op       (r_ctrl.op),
    .i_addr_lo  (r_alu[1:0]),
    .i_st_data  (r_rd2),
    .i_ld_raw   (dmem_rdata),
    .o_st_wdata (w_st_wdata),
    .o_st_be    (w_st_be),
    .o_ld_data  (w_ld_data),
    .o_misalign (w_misalign_raw)
  );

  // A store flag wins when both store and load-writeback are set
  assign w_load     = (r_ctrl.wb_ctr == WB_MEM);
  assign w_store    = r_ctrl.mem_we;
  assign w_mem_op   = w_load | w_store;
  assign w_misalign = w_mem_op & w_misalign_raw;
  assign w_pending  = w_mem_op & ~r_served & ~w_misalign;

  assign stall_m     = w_pending;
  assign misalign_m  = w_misalign;
  assign dmem_req    = w_pending & (r_state == IDLE);
  assign dmem_we     = w_store;
  assign dmem_addr   = ADDR_WIDTH'({r_alu[DATA_WIDTH-1:2], 2'b00});
  assign dmem_wdata  = w_st_wdata;
  assign dmem_be     = w_store ? w_st_be : '1;
  assign reg_wem     = r_ctrl.reg_we & ~w_misalign;
  assign rdm         = r_ctrl.rd;
  assign wb_ctrm     = r_ctrl.wb_ctr;
  assign alu_resultm = r_alu;
  assign pcnm        = r_pcn;
  assign read_datam  = r_read_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Handshake sequencing
  always_comb begin
    w_state_nxt  = r_state;
    w_served_set = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (dmem_req && dmem_gnt) begin
          if (w_store) w_served_set = 1'b1;
          else         w_state_nxt  = RESP;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          w_capture    = 1'b1;
          w_served_set = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl   <= '0;
      r_pcn    <= '0;
      r_alu    <= '0;
      r_rd2    <= '0;
      r_served <= 1'b0;
    end else if (!stall_m) begin
      r_ctrl   <= '{reg_we: reg_wee, op: ope, mem_we: mem_wee, rd: rde, wb_ctr: wb_ctre};
      r_pcn    <= pcne;
      r_alu    <= alu_result;
      r_rd2    <= rd2_ture;
      r_served <= 1'b0;
    end else if (w_served_set) begin
      r_served <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_read_data <= '0;
    else if (w_capture) r_read_data <= w_ld_data;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard: expected requests and load
// results are queued by the stimulus and checked by an independent monitor.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_wee = 1'b0;
  logic [2:0]  ope = 3'b000;
  logic        mem_wee = 1'b0;
  logic [4:0]  rde = 5'd0;
  logic [31:0] pcne = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] rd2_ture = '0;
  logic [1:0]  wb_ctre = 2'b00;
  logic        reg_wem;
  logic [4:0]  rdm;
  logic [1:0]  wb_ctrm;
  logic [31:0] alu_resultm;
  logic [31:0] pcnm;
  logic [31:0] read_datam;
  logic        stall_m;
  logic        misalign_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0BAD0BAD;

  int errors = 0;
  int checks = 0;

  req_t        exp_req[$];
  logic [31:0] exp_rd[$];

  // Responder configuration and state
  int          gnt_delay = 0;
  int          rv_delay  = 1;
  logic [31:0] rd_word   = '0;
  logic [31:0] rd_word_q = '0;
  int          g_cnt = 0;
  int          rv_cnt = 0;
  bit          rv_pend = 1'b0;
  bit          rv_seen = 1'b0;

  int          stalls;
  int          reqc;
  bit          done;
  logic        first_mis;
  logic        first_wem;
  logic [31:0] first_alu;
  logic [4:0]  first_rd;

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .reg_wee     (reg_wee),
    .ope         (ope),
    .mem_wee     (mem_wee),
    .rde         (rde),
    .pcne        (pcne),
    .alu_result  (alu_result),
    .rd2_ture    (rd2_ture),
    .wb_ctre     (wb_ctre),
    .reg_wem     (reg_wem),
    .rdm         (rdm),
    .wb_ctrm     (wb_ctrm),
    .alu_resultm (alu_resultm),
    .pcnm        (pcnm),
    .read_datam  (read_datam),
    .stall_m     (stall_m),
    .misalign_m  (misalign_m),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: gnt after gnt_delay request cycles, rvalid rv_delay cycles after gnt
  always @(posedge clk) begin
    #2;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0BAD0BAD;
    if (rv_pend) begin
      if (rv_cnt == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd_word_q;
        rv_pend     = 1'b0;
      end else begin
        rv_cnt--;
      end
    end else if (dmem_req) begin
      if (g_cnt >= gnt_delay) begin
        dmem_gnt = 1'b1;
        g_cnt    = 0;
        if (!dmem_we) begin
          rv_pend   = 1'b1;
          rv_cnt    = rv_delay - 1;
          rd_word_q = rd_word;
        end
      end else begin
        g_cnt++;
      end
    end else begin
      g_cnt = 0;
    end
  end

  // Monitor: checks accepted requests and the load result captured after rvalid
  always @(negedge clk) begin
    if (rv_seen) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid: read_datam %h with no expected load", read_datam);
      end else begin
        chk("read_datam", read_datam, exp_rd.pop_front());
      end
    end
    rv_seen = dmem_rvalid;
    if (dmem_req && dmem_gnt) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: addr %h we %b", dmem_addr, dmem_we);
      end else begin
        req_t e;
        e = exp_req.pop_front();
        chk("req_we", 32'(dmem_we), 32'(e.we));
        chk("req_addr", dmem_addr, e.addr);
        chk("req_be", 32'(dmem_be), 32'(e.be));
        if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
      end
    end
  end

  task automatic push_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
    exp_req.push_back(r);
  endtask

  // Issue one instruction from a negedge and follow it until it leaves stall
  task automatic issue(input string name, input logic rwe, input logic [2:0] op,
                       input logic mwe, input logic [1:0] wb, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] rword, input int gd,
                       input int rvd, input int exp_stall, input int exp_reqc);
    reg_wee = rwe; ope = op; mem_wee = mwe; wb_ctre = wb; alu_result = addr;
    rd2_ture = data; rde = addr[4:0]; pcne = 32'h1000 + addr;
    rd_word = rword; gnt_delay = gd; rv_delay = rvd;
    @(posedge clk);
    stalls = 0; reqc = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        first_mis = misalign_m; first_wem = reg_wem;
        first_alu = alu_resultm; first_rd = rdm;
      end
      if (dmem_req) begin
        reqc++;
        chk({name, "_addr_stable"}, dmem_addr, {addr[31:2], 2'b00});
      end
      if (stall_m) stalls++;
      else done = 1'b1;
    end
    chk({name, "_finished"}, 32'(done), 32'd1);
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    chk({name, "_req_cycles"}, 32'(reqc), 32'(exp_reqc));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall_m), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_read_data", read_datam, 32'd0);
    chk("rst_reg_wem", 32'(reg_wem), 32'd0);
    chk("rst_alu_resultm", alu_resultm, 32'd0);
    rst = 1'b0;

    push_req(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111);
    issue("sw", 1'b0, OP_W, 1'b1, WB_ALU, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 1, 1);

    push_req(1'b1, 32'h100, 32'hA5A5A5A5, 4'b1000);
    issue("sb", 1'b0, OP_B, 1'b1, WB_ALU, 32'h103, 32'h000000A5, 32'h0, 0, 1, 1, 1);

    push_req(1'b0, 32'h100, 32'h0, 4'b1111);
    exp_rd.push_back(32'hFFFFFFA5);
    issue("lb", 1'b1, OP_B, 1'b0, WB_MEM, 32'h103, 32'h0, 32'hA5000000, 0, 1, 2, 1);

    push_req(1'b0, 32'h100, 32'h0, 4'b1111);
    exp_rd.push_back(32'h000000A5);
    issue("lbu", 1'b1, OP_BU, 1'b0, WB_MEM, 32'h103, 32'h0, 32'hA5000000, 0, 1, 2, 1);

    push_req(1'b0, 32'h100, 32'h0, 4'b1111);
    exp_rd.push_back(32'hFFFF8001);
    issue("lh", 1'b1, OP_H, 1'b0, WB_MEM, 32'h102, 32'h0, 32'h80010000, 3, 2, 6, 4);

    issue("lw_misaligned", 1'b1, OP_W, 1'b0, WB_MEM, 32'h101, 32'h0, 32'h0, 0, 1, 0, 0);
    chk("lw_misaligned_flag", 32'(first_mis), 32'd1);
    chk("lw_misaligned_reg_wem", 32'(first_wem), 32'd0);

    issue("add", 1'b1, 3'b000, 1'b0, WB_ALU, 32'h55, 32'h0, 32'h0, 0, 1, 0, 0);
    chk("add_alu_resultm", first_alu, 32'h55);
    chk("add_reg_wem", 32'(first_wem), 32'd1);
    chk("add_misalign", 32'(first_mis), 32'd0);
    chk("add_rdm", 32'(first_rd), 32'h15);

    push_req(1'b0, 32'h200, 32'h0, 4'b1111);
    exp_rd.push_back(32'h12345678);
    issue("lw", 1'b1, OP_W, 1'b0, WB_MEM, 32'h200, 32'h0, 32'h12345678, 0, 1, 2, 1);
    chk("lw_alu_resultm", first_alu, 32'h200);

    push_req(1'b1, 32'h204, 32'hBEEFBEEF, 4'b1100);
    issue("sh_upper", 1'b0, OP_H, 1'b1, WB_ALU, 32'h206, 32'h1234BEEF, 32'h0, 0, 1, 1, 1);

    // Store flag plus load writeback select behaves as a store
    push_req(1'b1, 32'h208, 32'h11223344, 4'b1111);
    issue("store_wins", 1'b1, OP_W, 1'b1, WB_MEM, 32'h208, 32'h11223344, 32'h0, 0, 1, 1, 1);

    // Reset while waiting for a response; the stray rvalid must be ignored
    reg_wee = 1'b1; ope = OP_W; mem_wee = 1'b0; wb_ctre = WB_MEM; alu_result = 32'h300;
    rd_word = 32'hCAFEF00D; gnt_delay = 0; rv_delay = 8;
    push_req(1'b0, 32'h300, 32'h0, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("resp_stall", 32'(stall_m), 32'd1);
    reg_wee = 1'b0; ope = 3'b000; wb_ctre = WB_ALU; alu_result = '0;
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(dmem_req), 32'd0);
    chk("async_rst_stall", 32'(stall_m), 32'd0);
    chk("async_rst_read_data", read_datam, 32'd0);
    chk("async_rst_reg_wem", 32'(reg_wem), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_rd.push_back(32'h0);
    repeat (12) @(negedge clk);
    chk("post_rst_stall", 32'(stall_m), 32'd0);
    chk("post_rst_req", 32'(dmem_req), 32'd0);

    push_req(1'b0, 32'h300, 32'h0, 4'b1111);
    exp_rd.push_back(32'hFFFFFFF0);
    issue("lb_after_rst", 1'b1, OP_B, 1'b0, WB_MEM, 32'h300, 32'h0, 32'h000000F0, 0, 1, 2, 1);

    reg_wee = 1'b0; ope = 3'b000; mem_wee = 1'b0; wb_ctre = WB_ALU;
    repeat (3) @(negedge clk);
    chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
